// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard decoder: frame states,
// prefix/ignore byte values and the ps2_key field layout.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } frame_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;
    localparam logic [7:0] BYTE_E1 = 8'hE1;
    localparam logic [7:0] BYTE_AA = 8'hAA;
    localparam logic [7:0] BYTE_FA = 8'hFA;
    localparam logic [7:0] BYTE_FE = 8'hFE;
    localparam logic [7:0] BYTE_EE = 8'hEE;
    localparam logic [7:0] BYTE_00 = 8'h00;
    localparam logic [7:0] BYTE_FF = 8'hFF;

    localparam logic [2:0] SKIP_LOAD = 3'd7;

    localparam int KEY_TOGGLE_BIT = 10;
    localparam int KEY_PRESS_BIT  = 9;
    localparam int KEY_EXT_BIT    = 8;
    localparam int KEY_CODE_MSB   = 7;

    // Keyboard housekeeping replies that carry no key information.
    function automatic logic is_ignore_byte(input logic [7:0] b);
        return (b == BYTE_AA) || (b == BYTE_FA) || (b == BYTE_FE) ||
               (b == BYTE_EE) || (b == BYTE_00) || (b == BYTE_FF);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key outputs bundled for the decoder.
interface ps2_key_decoder_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [10:0] ps2_key;
    logic        frame_err;

    modport master (output ps2_clk, ps2_data, input ps2_key, frame_err);
    modport slave  (input ps2_clk, ps2_data, output ps2_key, frame_err);
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchronizer followed by a run-length glitch filter: the output
// level flips only after FILTER_LEN consecutive differing samples.
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          level_reg;
    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            level_reg <= 1'b1;
            cnt_reg   <= '0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            if (sync2_reg != level_reg) begin
                if (cnt_reg == CW'(FILTER_LEN - 1)) begin
                    level_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign level = level_reg;
endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard frame receiver and scan-code decoder producing toggle-flagged
// key events with press/release and extended qualifiers.
module ps2_key_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic clk,
    input  logic rst_n,
    ps2_key_decoder_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] line_raw;
    logic [1:0] line_level;

    assign line_raw = {bus.ps2_data, bus.ps2_clk};

    // Line 0 is the PS/2 clock (debounced), line 1 is data (sync only).
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
        ps2_line_filter #(
            .FILTER_LEN((gi == 0) ? FILTER_LEN : 1)
        ) u_filter (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (line_raw[gi]),
            .level (line_level[gi])
        );
    end

    logic         clk_prev_reg;
    logic         clk_fall;
    logic         data_bit;
    frame_state_t state_reg;
    logic [2:0]   bit_cnt_reg;
    logic [7:0]   shift_reg;
    logic         parity_reg;
    logic         ext_reg;
    logic         rel_reg;
    logic [2:0]   skip_reg;
    logic [TW-1:0] tout_reg;
    logic [10:0]  key_reg;
    logic         err_reg;

    assign clk_fall = clk_prev_reg & ~line_level[0];
    assign data_bit = line_level[1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            clk_prev_reg <= 1'b1;
            state_reg    <= ST_IDLE;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            parity_reg   <= 1'b0;
            ext_reg      <= 1'b0;
            rel_reg      <= 1'b0;
            skip_reg     <= '0;
            tout_reg     <= '0;
            key_reg      <= '0;
            err_reg      <= 1'b0;
        end else begin
            clk_prev_reg <= line_level[0];
            err_reg      <= 1'b0;
            if (state_reg == ST_IDLE || clk_fall) begin
                tout_reg <= '0;
            end else begin
                tout_reg <= tout_reg + TW'(1);
            end

            if (state_reg != ST_IDLE && !clk_fall &&
                tout_reg == TW'(TIMEOUT_CYCLES - 1)) begin
                err_reg   <= 1'b1;
                ext_reg   <= 1'b0;
                rel_reg   <= 1'b0;
                state_reg <= ST_IDLE;
            end else if (clk_fall) begin
                case (state_reg)
                    ST_IDLE: begin
                        if (!data_bit) begin
                            state_reg   <= ST_DATA;
                            bit_cnt_reg <= '0;
                        end
                    end
                    ST_DATA: begin
                        shift_reg   <= {data_bit, shift_reg[7:1]};
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                        if (bit_cnt_reg == 3'd7) begin
                            state_reg <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        parity_reg <= data_bit;
                        state_reg  <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_reg <= ST_IDLE;
                        // Odd parity: data plus parity bit must hold an odd count of ones.
                        if (!data_bit || !(^shift_reg ^ parity_reg)) begin
                            err_reg <= 1'b1;
                            ext_reg <= 1'b0;
                            rel_reg <= 1'b0;
                        end else if (skip_reg != 3'd0) begin
                            skip_reg <= skip_reg - 3'd1;
                        end else if (shift_reg == BYTE_E1) begin
                            skip_reg <= SKIP_LOAD;
                        end else if (shift_reg == BYTE_E0) begin
                            ext_reg <= 1'b1;
                        end else if (shift_reg == BYTE_F0) begin
                            rel_reg <= 1'b1;
                        end else if (!(is_ignore_byte(shift_reg) && !ext_reg && !rel_reg)) begin
                            key_reg[KEY_TOGGLE_BIT]   <= ~key_reg[KEY_TOGGLE_BIT];
                            key_reg[KEY_PRESS_BIT]    <= ~rel_reg;
                            key_reg[KEY_EXT_BIT]      <= ext_reg;
                            key_reg[KEY_CODE_MSB:0]   <= shift_reg;
                            ext_reg <= 1'b0;
                            rel_reg <= 1'b0;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.ps2_key   = key_reg;
    assign bus.frame_err = err_reg;
endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical samples needed before the filtered ps2_clk level changes.
REQ-002 Parameter TIMEOUT_CYCLES, default 100000: clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted.
REQ-003 clk  input  1  system clock; single clock domain; every flop is clocked on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous, active-low.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous to clk, idles high.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous to clk, idles high.
REQ-007 ps2_key  output  11  decoded key event: [10] toggles once per event, [9] pressed (1) or released (0), [8] extended (E0-prefixed), [7:0] scan code.
REQ-008 frame_err  output  1  one-cycle pulse on a parity, start, stop or timeout error.

Function
REQ-009 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer.
REQ-010 Filtered ps2_clk SHALL change level only after FILTER_LEN consecutive synchronized samples differ from the current filtered level; any shorter glitch SHALL be ignored.
REQ-011 ps2_data SHALL be sampled on the clk cycle in which the filtered ps2_clk falling edge is detected.
REQ-012 The frame FSM SHALL have states IDLE, DATA, PARITY and STOP; IDLE->DATA on a sampled 0, otherwise stay in IDLE; DATA collects 8 bits LSB first, then ->PARITY; PARITY->STOP; STOP->IDLE.
REQ-013 Parity SHALL be odd over the 8 data bits plus the parity bit; a mismatch SHALL be flagged at STOP.
REQ-014 A stop bit of 0 or a parity mismatch SHALL discard the byte, pulse frame_err, clear the E0/F0 flags and return to IDLE.
REQ-015 A timeout counter SHALL reset on every filtered falling edge and run while the FSM is not in IDLE; on reaching TIMEOUT_CYCLES it SHALL pulse frame_err, clear the prefix flags and force IDLE.
REQ-016 Byte 0xE0 SHALL set the ext flag, and byte 0xF0 SHALL set the release flag; neither byte emits an event.
REQ-017 Byte 0xE1 SHALL load a skip counter with 7; while the counter is non-zero, each received byte SHALL only decrement it.
REQ-018 Bytes 0xAA, 0xFA, 0xFE, 0xEE, 0x00 and 0xFF received with no prefix flag set SHALL be dropped silently.
REQ-019 Any other byte SHALL update ps2_key <= {~ps2_key[10], ~release, ext, byte} and clear both prefix flags.
REQ-020 ps2_key and frame_err SHALL update on the clk cycle after the stop-bit falling edge is detected (1-cycle latency); ps2_key holds its value between events.
REQ-021 ps2_key[10] SHALL toggle exactly once per emitted event and never on a prefix, skipped, dropped or errored byte.

Reset
REQ-022 While rst_n=0 at a clk edge: ps2_key=11'h000, frame_err=0, FSM=IDLE, prefix flags=0, skip and timeout counters=0, filtered and synchronizer levels=1.
REQ-023 Reset asserted mid-frame SHALL abandon the partial byte without a frame_err pulse; the first frame after release SHALL decode normally.

Structure
REQ-024 A shared package ps2_pkg SHALL hold the FSM state enum, the prefix and ignore byte constants (E0, F0, E1, AA, FA, FE, EE, 00, FF) and the ps2_key field bit positions.
REQ-025 Synchronizer plus glitch filter SHALL be a sub-module ps2_line_filter, instantiated once per line (FILTER_LEN=1 on data).

Verification
REQ-026 Frame 0x1C (parity 0) -> ps2_key goes from 11'h000 to 11'h61C, frame_err stays 0.
REQ-027 Bytes E0, F0, 70 -> exactly one event, ps2_key[9:0]=10'h170, bit 10 toggled once.
REQ-028 Frame 0x29 with a bad parity bit -> frame_err pulses high for 1 cycle and ps2_key is unchanged; next good 0x29 -> ps2_key[9:0]=10'h229.
REQ-029 Stall after 4 data bits for TIMEOUT_CYCLES -> frame_err pulse; the following 0x5A -> ps2_key[9:0]=10'h25A.
REQ-030 Pause sequence E1 14 77 E1 F0 14 F0 77 then 0x05 -> a single event 10'h205; FILTER_LEN-1 cycle low glitch on ps2_clk mid-frame -> byte still decoded correctly.
